// File: rtl/titan_lsu_wb.sv
`timescale 1ns/1ps
// titan_lsu_wb
// Load/store unit between the MEM stage and a Wishbone-style data bus.
// It steers byte lanes from the low address bits, rejects misaligned
// accesses without touching the bus, and reports bus errors and timeouts.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   maddr_i, mdat_i        access address and right-aligned store data
//   mread_i, mwrite_i      load / store request (level, held while stalled)
//   msize_i, munsigned_i   access size (byte/half/word) and zero-extend flag
//   mkill_i                abort the current request
//   dstall_o               combinational pipeline stall
//   data_o                 formatted load data (held until the next load)
//   ld/st_fault_o          one-cycle bus-error/timeout pulse
//   ld/st_mis_o            one-cycle misalignment pulse
//   badaddr_o              faulting address, valid with any pulse
//   daddr_o, ddat_o,       word-aligned bus address, lane-replicated data,
//   dsel_o, dcyc_o,        byte selects, cycle, strobe, write enable
//   dstb_o, dwe_o
//   ddat_i, dack_i, derr_i bus read data, acknowledge, error
module titan_lsu_wb #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] maddr_i,
  input  logic [31:0]   mdat_i,
  input  logic          mread_i,
  input  logic          mwrite_i,
  input  logic [1:0]    msize_i,
  input  logic          munsigned_i,
  input  logic          mkill_i,
  output logic          dstall_o,
  output logic [31:0]   data_o,
  output logic          ld_fault_o,
  output logic          st_fault_o,
  output logic          ld_mis_o,
  output logic          st_mis_o,
  output logic [AW-1:0] badaddr_o,
  output logic [AW-1:0] daddr_o,
  output logic [31:0]   ddat_o,
  output logic [3:0]    dsel_o,
  output logic          dcyc_o,
  output logic          dstb_o,
  output logic          dwe_o,
  input  logic [31:0]   ddat_i,
  input  logic          dack_i,
  input  logic          derr_i
);

  // Counter wide enough to reach TIMEOUT; with the timeout disabled it just wraps.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] raw, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] lane;
    logic [31:0] res;
    lane = raw >> {off, 3'b000};
    case (size)
      2'b00:   res = uns ? {24'h000000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   res = uns ? {16'h0000, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_q, bus_d;
  logic          dwe_q, dwe_d;
  logic [3:0]    dsel_q, dsel_d;
  logic [31:0]   ddat_q, ddat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   data_q, data_d;
  logic [AW-1:0] badaddr_q, badaddr_d;
  logic          ld_fault_q, ld_fault_d;
  logic          st_fault_q, st_fault_d;
  logic          ld_mis_q, ld_mis_d;
  logic          st_mis_q, st_mis_d;

  logic          req_s;
  logic          mis_s;
  logic          timeout_s;

  assign req_s     = mread_i ^ mwrite_i;
  assign mis_s     = misaligned(msize_i, maddr_i[1:0]);
  assign timeout_s = (TIMEOUT > 0) && (cnt_q == TO_V);

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus_d      = bus_q;
    dwe_d      = dwe_q;
    dsel_d     = dsel_q;
    ddat_d     = ddat_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    data_d     = data_q;
    badaddr_d  = badaddr_q;
    // Pulses default low so they last exactly the DONE cycle.
    ld_fault_d = 1'b0;
    st_fault_d = 1'b0;
    ld_mis_d   = 1'b0;
    st_mis_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s && !mkill_i) begin
          if (mis_s) begin
            ld_mis_d  = mread_i;
            st_mis_d  = mwrite_i;
            badaddr_d = maddr_i;
            state_d   = S_DONE;
          end else begin
            addr_d  = maddr_i;
            dsel_d  = lane_sel(msize_i, maddr_i[1:0]);
            ddat_d  = lane_data(msize_i, mdat_i);
            dwe_d   = mwrite_i;
            size_d  = msize_i;
            uns_d   = munsigned_i;
            bus_d   = 1'b1;
            cnt_d   = {CW{1'b0}};
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (mkill_i) begin
          bus_d   = 1'b0;
          state_d = S_IDLE;
        end else if (derr_i || (!dack_i && timeout_s)) begin
          // A timeout is reported exactly like a bus error.
          bus_d      = 1'b0;
          ld_fault_d = !dwe_q;
          st_fault_d = dwe_q;
          badaddr_d  = addr_q;
          state_d    = S_DONE;
        end else if (dack_i) begin
          bus_d = 1'b0;
          if (!dwe_q) begin
            data_d = fmt_load(ddat_i, addr_q[1:0], size_q, uns_q);
          end else begin
            data_d = data_q;
          end
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        bus_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any bus cycle in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      bus_q      <= 1'b0;
      dwe_q      <= 1'b0;
      dsel_q     <= 4'h0;
      ddat_q     <= 32'h0000_0000;
      addr_q     <= {AW{1'b0}};
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      data_q     <= 32'h0000_0000;
      badaddr_q  <= {AW{1'b0}};
      ld_fault_q <= 1'b0;
      st_fault_q <= 1'b0;
      ld_mis_q   <= 1'b0;
      st_mis_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bus_q      <= bus_d;
      dwe_q      <= dwe_d;
      dsel_q     <= dsel_d;
      ddat_q     <= ddat_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      data_q     <= data_d;
      badaddr_q  <= badaddr_d;
      ld_fault_q <= ld_fault_d;
      st_fault_q <= st_fault_d;
      ld_mis_q   <= ld_mis_d;
      st_mis_q   <= st_mis_d;
    end
  end

  // The stall drops in DONE so the core advances exactly once per access.
  assign dstall_o   = req_s && !mkill_i && (state_q != S_DONE);
  assign data_o     = data_q;
  assign ld_fault_o = ld_fault_q;
  assign st_fault_o = st_fault_q;
  assign ld_mis_o   = ld_mis_q;
  assign st_mis_o   = st_mis_q;
  assign badaddr_o  = badaddr_q;
  assign daddr_o    = {addr_q[AW-1:2], 2'b00};
  assign ddat_o     = ddat_q;
  assign dsel_o     = dsel_q;
  assign dcyc_o     = bus_q;
  assign dstb_o     = bus_q;
  assign dwe_o      = dwe_q;

endmodule
